// File: rtl/pnr_window_classifier.sv
// Photon-number classifier: windowed peak tracking, N_THR-threshold popcount, saturating histogram.
// Optional feature: define BASELINE_SUB_EN to subtract the trigger-cycle sample from every metric.
module pnr_window_classifier #(
    parameter int ADC_W   = 14,
    parameter int N_THR   = 8,
    parameter int NUM_W   = $clog2(N_THR + 1),
    parameter int CNT_W   = 32,
    parameter int MAX_WIN = 256
) (
    input  logic                   ADC_CLK,
    input  logic                   rst_i,
    input  logic                   trigger,
    input  logic                   delayed_trigger,
    input  logic [ADC_W-1:0]       pnr_source_sig,
    input  logic [N_THR*ADC_W-1:0] thresholds_i,
    output logic [NUM_W-1:0]       photon_num,
    output logic                   photon_valid,
    output logic [ADC_W-1:0]       peak_value,
    output logic                   busy,
    output logic                   timeout,
    input  logic                   hist_clear,
    input  logic [NUM_W-1:0]       hist_rd_addr,
    output logic [CNT_W-1:0]       hist_rd_data
);

    localparam int WC_W = $clog2(MAX_WIN + 1);

    typedef enum logic [1:0] {IDLE, WINDOW, CLASSIFY, REPORT} state_t;

    state_t            state_q;
    logic [ADC_W-1:0]  peak_q;
    logic [WC_W-1:0]   win_cnt_q;
    logic [NUM_W-1:0]  photon_num_q;
    logic              photon_valid_q;
    logic [ADC_W-1:0]  peak_value_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  hist_q [N_THR+1];
    logic [CNT_W-1:0]  hist_rd_data_q;

    logic [ADC_W-1:0]  metric;
    logic [ADC_W-1:0]  peak_init;
    logic [NUM_W-1:0]  cls_num_d;

`ifdef BASELINE_SUB_EN
    logic [ADC_W-1:0]  base_q;
    logic [ADC_W:0]    diff;

    // Borrow bit set means the sample is below baseline: clamp to zero.
    assign diff      = {1'b0, pnr_source_sig} - {1'b0, base_q};
    assign metric    = diff[ADC_W] ? '0 : diff[ADC_W-1:0];
    assign peak_init = '0;

    always_ff @(posedge ADC_CLK) begin
        if (rst_i)
            base_q <= '0;
        else if (state_q == IDLE && trigger)
            base_q <= pnr_source_sig;
    end
`else
    assign metric    = pnr_source_sig;
    assign peak_init = pnr_source_sig;
`endif

    always_comb begin
        cls_num_d = '0;
        for (int k = 0; k < N_THR; k++)
            if (peak_q >= thresholds_i[k*ADC_W +: ADC_W])
                cls_num_d = cls_num_d + NUM_W'(1);
    end

    always_ff @(posedge ADC_CLK) begin
        if (rst_i) begin
            state_q        <= IDLE;
            peak_q         <= '0;
            win_cnt_q      <= '0;
            photon_num_q   <= '0;
            photon_valid_q <= 1'b0;
            peak_value_q   <= '0;
            timeout_q      <= 1'b0;
        end else begin
            photon_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        peak_q    <= peak_init;
                        win_cnt_q <= WC_W'(1);
                        state_q   <= delayed_trigger ? CLASSIFY : WINDOW;
                    end
                end
                WINDOW: begin
                    if (metric > peak_q)
                        peak_q <= metric;
                    win_cnt_q <= win_cnt_q + WC_W'(1);
                    if (delayed_trigger) begin
                        state_q <= CLASSIFY;
                    end else if (win_cnt_q == WC_W'(MAX_WIN - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                // Result is registered here so photon_valid is visible during REPORT.
                CLASSIFY: begin
                    photon_num_q   <= cls_num_d;
                    peak_value_q   <= peak_q;
                    photon_valid_q <= 1'b1;
                    state_q        <= REPORT;
                end
                REPORT: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (rst_i || hist_clear) begin
            for (int k = 0; k <= N_THR; k++)
                hist_q[k] <= '0;
        end else if (state_q == REPORT) begin
            for (int k = 0; k <= N_THR; k++)
                if (NUM_W'(k) == photon_num_q && hist_q[k] != '1)
                    hist_q[k] <= hist_q[k] + CNT_W'(1);
        end
    end

    // Addresses above N_THR match no bin and read back as zero.
    always_ff @(posedge ADC_CLK) begin
        if (rst_i) begin
            hist_rd_data_q <= '0;
        end else begin
            hist_rd_data_q <= '0;
            for (int k = 0; k <= N_THR; k++)
                if (NUM_W'(k) == hist_rd_addr)
                    hist_rd_data_q <= hist_q[k];
        end
    end

    assign photon_num   = photon_num_q;
    assign photon_valid = photon_valid_q;
    assign peak_value   = peak_value_q;
    assign timeout      = timeout_q;
    assign busy         = (state_q != IDLE);
    assign hist_rd_data = hist_rd_data_q;

endmodule

// File: tb/tb_pnr_window_classifier.sv
// Scoreboard bench for pnr_window_classifier; a second CNT_W=4 instance shares stimulus for saturation.
module tb_pnr_window_classifier;
    localparam int ADC_W = 14, N_THR = 8, NUM_W = 4, CNT_W = 32, MAX_WIN = 256;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic                   rst, trig, dtrig, hclr;
    logic [ADC_W-1:0]       samp;
    logic [N_THR*ADC_W-1:0] thr;
    logic [NUM_W-1:0]       raddr;

    logic [NUM_W-1:0] pnum, s_pnum;
    logic             pvalid, s_pvalid, busy, s_busy, tmo, s_tmo;
    logic [ADC_W-1:0] pk, s_pk;
    logic [CNT_W-1:0] rdata;
    logic [3:0]       s_rdata;

    pnr_window_classifier #(.ADC_W(ADC_W), .N_THR(N_THR), .CNT_W(CNT_W), .MAX_WIN(MAX_WIN)) dut (
        .ADC_CLK(clk), .rst_i(rst), .trigger(trig), .delayed_trigger(dtrig),
        .pnr_source_sig(samp), .thresholds_i(thr), .photon_num(pnum), .photon_valid(pvalid),
        .peak_value(pk), .busy(busy), .timeout(tmo), .hist_clear(hclr),
        .hist_rd_addr(raddr), .hist_rd_data(rdata));

    pnr_window_classifier #(.ADC_W(ADC_W), .N_THR(N_THR), .CNT_W(4), .MAX_WIN(MAX_WIN)) u_sat (
        .ADC_CLK(clk), .rst_i(rst), .trigger(trig), .delayed_trigger(dtrig),
        .pnr_source_sig(samp), .thresholds_i(thr), .photon_num(s_pnum), .photon_valid(s_pvalid),
        .peak_value(s_pk), .busy(s_busy), .timeout(s_tmo), .hist_clear(hclr),
        .hist_rd_addr(raddr), .hist_rd_data(s_rdata));

    typedef struct {
        bit is_tmo;
        int num;
        int peak;
        int at;
    } exp_t;

    exp_t q[$];
    int   smp[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue, including its cycle.
    exp_t me;
    always @(negedge clk) begin
        if (!rst && (pvalid || tmo)) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: valid=%0b timeout=%0b at cyc %0d, none expected",
                         pvalid, tmo, cyc);
            end else begin
                me = q.pop_front();
                chk("strobe_cycle", 64'(cyc), 64'(me.at));
                chk("timeout_strobe", 64'(tmo), 64'(me.is_tmo));
                chk("valid_strobe", 64'(pvalid), 64'(!me.is_tmo));
                if (!me.is_tmo) begin
                    chk("photon_num", 64'(pnum), 64'(me.num));
                    chk("peak_value", 64'(pk), 64'(me.peak));
                end
            end
        end
    end

    // Drives smp[] as one window: trigger on the first sample, delayed_trigger on the last.
    task automatic run_win(input int again_at, input int exp_n, input int exp_pk, input bit clr_rep);
        exp_t e;
        for (int i = 0; i < smp.size(); i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_in_window", 64'(busy), 64'd1);
            hclr  = 1'b0;
            trig  = (i == 0) || (i == again_at);
            dtrig = (i == smp.size() - 1);
            samp  = ADC_W'(smp[i]);
            if (dtrig) begin
                e.is_tmo = 1'b0; e.num = exp_n; e.peak = exp_pk; e.at = cyc + 2;
                q.push_back(e);
            end
        end
        @(negedge clk);
        trig = 1'b0; dtrig = 1'b0; samp = '0;
        @(negedge clk);
        hclr = clr_rep;
        if (clr_rep) begin
            @(negedge clk);
            hclr = 1'b0;
        end
    endtask

    task automatic rd_bin(input int a, input logic [63:0] exp, input string nm);
        @(negedge clk);
        raddr = NUM_W'(a);
        @(negedge clk);
        chk(nm, 64'(rdata), exp);
    endtask

    initial begin
        exp_t e;
        for (int k = 0; k < N_THR; k++) thr[k*ADC_W +: ADC_W] = ADC_W'(500 + 1000 * k);
        rst = 1'b1; trig = 1'b0; dtrig = 1'b0; hclr = 1'b0; samp = '0; raddr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_photon_num", 64'(pnum), 64'd0);
        chk("reset_peak_value", 64'(pk), 64'd0);
        chk("reset_valid", 64'(pvalid), 64'd0);
        chk("reset_timeout", 64'(tmo), 64'd0);
        chk("reset_hist", 64'(rdata), 64'd0);

        // Ramp peaking at 3600 over 51 samples
        smp = {};
        for (int i = 0; i <= 50; i++) smp.push_back(i <= 36 ? i * 100 : 3600 - (i - 36) * 100);
        run_win(-1, 4, 3600, 1'b0);
        // Back-to-back windows: exact threshold, below all, above all
        smp = {0, 800, 1500, 1200};  run_win(-1, 2, 1500, 1'b0);
        smp = {0, 400, 300};         run_win(-1, 0, 400, 1'b0);
        smp = {0, 7600, 7000};       run_win(-1, 8, 7600, 1'b0);
        rd_bin(8, 1, "hist_bin8");
        rd_bin(4, 1, "hist_bin4");
        rd_bin(2, 1, "hist_bin2");
        rd_bin(0, 1, "hist_bin0");
        rd_bin(9, 0, "hist_addr9");
        rd_bin(15, 0, "hist_addr15");

        // delayed_trigger alone in IDLE does nothing
        @(negedge clk); dtrig = 1'b1;
        @(negedge clk); dtrig = 1'b0;
        @(negedge clk); chk("lone_dtrig_busy", 64'(busy), 64'd0);

        // Window without delayed_trigger times out
        @(negedge clk);
        trig = 1'b1; samp = 14'd5000;
        e.is_tmo = 1'b1; e.num = 0; e.peak = 0; e.at = cyc + MAX_WIN;
        q.push_back(e);
        @(negedge clk); trig = 1'b0; samp = '0;
        repeat (MAX_WIN + 4) @(negedge clk);
        chk("timeout_busy", 64'(busy), 64'd0);
        rd_bin(5, 0, "timeout_bin5");
        rd_bin(0, 1, "timeout_bin0");

        // One-sample window, then a re-trigger inside a window
`ifdef BASELINE_SUB_EN
        smp = {5000};                run_win(-1, 0, 0, 1'b0);
`else
        smp = {5000};                run_win(-1, 5, 5000, 1'b0);
`endif
        smp = {0, 0, 6000, 0, 100, 0, 0};  run_win(4, 6, 6000, 1'b0);
        rd_bin(6, 1, "hist_bin6");

        // Baseline 1000, peak 2600
`ifdef BASELINE_SUB_EN
        smp = {1000, 1200, 2600, 1800};  run_win(-1, 2, 1600, 1'b0);
`else
        smp = {1000, 1200, 2600, 1800};  run_win(-1, 3, 2600, 1'b0);
`endif

        // hist_clear coincides with the REPORT increment
        smp = {0, 2600, 0};  run_win(-1, 3, 2600, 1'b1);
        rd_bin(3, 0, "clear_bin3");
        rd_bin(6, 0, "clear_bin6");
        rd_bin(8, 0, "clear_bin8");

        // 16 events into bin 0: 32-bit counts on, 4-bit saturates at 15
        for (int r = 0; r < 16; r++) begin
            smp = {0, 100};  run_win(-1, 0, 100, 1'b0);
        end
        rd_bin(0, 16, "count_bin0");
        chk("sat_bin0", 64'(s_rdata), 64'd15);

        // Reset mid-window
        @(negedge clk); trig = 1'b1; samp = '0;
        @(negedge clk); trig = 1'b0; samp = 14'd3000;
        @(negedge clk); samp = '0;
        chk("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(pvalid), 64'd0);
        chk("rst_timeout", 64'(tmo), 64'd0);
        rd_bin(0, 0, "rst_hist_bin0");
        repeat (MAX_WIN + 10) @(negedge clk);
        chk("rst_busy_later", 64'(busy), 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
